// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port word memory: sub-word store via read-modify-write,
// load lane extraction with sign/zero extend. Define DMEM_ARB_CORE_PRIO_EN for fixed port-0 priority.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [1:0]        p0_size_i,
    input  logic              p0_uns_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic [DATA_W-1:0] p0_rdata_o,
    output logic              p0_ack_o,
    output logic              p0_err_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [1:0]        p1_size_i,
    input  logic              p1_uns_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              p1_ack_o,
    output logic              p1_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_RMW_WR = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    logic [2:0]        state_reg;
    logic              gnt_reg;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;
    logic [DATA_W-1:0] word_reg;

    logic              grant_sel;
    logic              any_req;
    logic              req_we;
    logic              req_uns;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_bad;

    assign any_req = p0_req_i | p1_req_i;

`ifdef DMEM_ARB_CORE_PRIO_EN
    assign grant_sel = !p0_req_i;
`else
    logic rr_ptr_reg;

    assign grant_sel = (p0_req_i && p1_req_i) ? rr_ptr_reg : !p0_req_i;

    // Pointer only moves on contention so a lone requester never loses its turn.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && p0_req_i && p1_req_i) begin
            rr_ptr_reg <= !grant_sel;
        end
    end
`endif

    assign req_we    = grant_sel ? p1_we_i    : p0_we_i;
    assign req_uns   = grant_sel ? p1_uns_i   : p0_uns_i;
    assign req_size  = grant_sel ? p1_size_i  : p0_size_i;
    assign req_addr  = grant_sel ? p1_addr_i  : p0_addr_i;
    assign req_wdata = grant_sel ? p1_wdata_i : p0_wdata_i;

    assign req_bad = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= 1'b0;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            uns_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
            word_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_reg   <= grant_sel;
                        we_reg    <= req_we;
                        size_reg  <= req_size;
                        uns_reg   <= req_uns;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        err_reg   <= req_bad;
                        if (req_bad)
                            state_reg <= ST_RESP;
                        else if (req_we && req_size == 2'b10)
                            state_reg <= ST_WRITE;
                        else
                            state_reg <= ST_READ;
                    end
                end
                // A store reaching READ is always sub-word, so we_reg doubles as the RMW flag.
                ST_READ: begin
                    word_reg  <= mem_rdata_i;
                    state_reg <= we_reg ? ST_RMW_WR : ST_RESP;
                end
                ST_RMW_WR: state_reg <= ST_RESP;
                ST_WRITE:  state_reg <= ST_RESP;
                ST_RESP:   state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] merged;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;
            assign hit = (size_reg == 2'b00) ? (addr_reg[1:0] == LANE) : (addr_reg[1] == LANE[1]);
            assign src = (size_reg == 2'b00 || !LANE[0]) ? wdata_reg[7:0] : wdata_reg[15:8];
            assign merged[8*gi +: 8] = hit ? src : word_reg[8*gi +: 8];
        end
    endgenerate

    logic [15:0]       lane_data;
    logic [DATA_W-1:0] load_data;

    assign lane_data = 16'(word_reg >> {addr_reg[1:0], 3'b000});

    always_comb begin
        load_data = '0;
        if (!we_reg && !err_reg) begin
            case (size_reg)
                2'b00:   load_data = uns_reg ? {24'd0, lane_data[7:0]}
                                             : {{24{lane_data[7]}}, lane_data[7:0]};
                2'b01:   load_data = uns_reg ? {16'd0, lane_data}
                                             : {{16{lane_data[15]}}, lane_data};
                default: load_data = word_reg;
            endcase
        end
    end

    logic resp;

    assign resp       = (state_reg == ST_RESP);
    assign p0_ack_o   = resp && !gnt_reg;
    assign p1_ack_o   = resp && gnt_reg;
    assign p0_err_o   = p0_ack_o && err_reg;
    assign p1_err_o   = p1_ack_o && err_reg;
    assign p0_rdata_o = p0_ack_o ? load_data : '0;
    assign p1_rdata_o = p1_ack_o ? load_data : '0;

    assign mem_re_o    = (state_reg == ST_READ);
    assign mem_we_o    = (state_reg == ST_RMW_WR) || (state_reg == ST_WRITE);
    assign mem_addr_o  = (mem_re_o || mem_we_o) ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata_o = (state_reg == ST_RMW_WR) ? merged
                       : (state_reg == ST_WRITE)  ? wdata_reg : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-level reference memory model, per-port expectation
// queues popped by a monitor on each ack, plus directed latency/strobe/arbitration/reset checks.
module tb_dmem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_load;
    } exp_t;

    logic        clk_i;
    logic        reset_n;
    logic        req   [2];
    logic        wr    [2];
    logic [1:0]  size  [2];
    logic        uns   [2];
    logic [4:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    logic [31:0] mem [8];
    logic [31:0] init_words [8];
    logic        load_mem;
    logic [7:0]  ref_mem [32];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   grant_log[$];
    int   errors = 0;
    int   checks = 0;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .p0_req_i(req[0]), .p0_we_i(wr[0]), .p0_size_i(size[0]), .p0_uns_i(uns[0]),
        .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]), .p0_rdata_o(rdata[0]),
        .p0_ack_o(ack[0]), .p0_err_o(err[0]),
        .p1_req_i(req[1]), .p1_we_i(wr[1]), .p1_size_i(size[1]), .p1_uns_i(uns[1]),
        .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]), .p1_rdata_o(rdata[1]),
        .p1_ack_o(ack[1]), .p1_err_o(err[1]),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_re_o(mem_re), .mem_rdata_i(mem_rdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural memory standing in for the data RAM.
    assign mem_rdata = mem[mem_addr[4:2]];
    always @(posedge clk_i) begin
        if (load_mem) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_words[i];
        end else if (mem_we) begin
            mem[mem_addr[4:2]] <= mem_wdata;
        end
    end

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic bit outs_zero();
        return rdata[0] == 32'd0 && ack[0] == 1'b0 && err[0] == 1'b0
            && rdata[1] == 32'd0 && ack[1] == 1'b0 && err[1] == 1'b0
            && mem_addr == 5'd0 && mem_wdata == 32'd0 && !mem_we && !mem_re;
    endfunction

    // Reference model: little-endian byte array, rules applied directly.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [4:0] a, input logic [31:0] wd, output exp_t e);
        int          nbytes;
        logic [31:0] val;
        e.err     = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        e.is_load = !w;
        e.rdata   = 32'd0;
        if (!e.err) begin
            nbytes = 1 << sz;
            if (w) begin
                for (int i = 0; i < nbytes; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[int'(a) + i]) << (8*i));
                if (!u && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8*nbytes));
                e.rdata = val;
            end
        end
    endtask

    task automatic push_exp(input int p, input exp_t e);
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic issue(input int p, input logic w, input logic [1:0] sz, input logic u,
                         input logic [4:0] a, input logic [31:0] wd, input bit chk);
        exp_t e;
        int   cyc = 0, nre = 0, nwe = 0, exp_lat, exp_re, exp_we;
        bit   done = 0;
        @(posedge clk_i); #1;
        model(w, sz, u, a, wd, e);
        push_exp(p, e);
        wr[p] = w; size[p] = sz; uns[p] = u; addr[p] = a; wdata[p] = wd; req[p] = 1'b1;
        while (!done && cyc < 50) begin
            @(posedge clk_i); #1;
            cyc++;
            if (mem_re) nre++;
            if (mem_we) nwe++;
            if (ack[p]) done = 1;
        end
        req[p] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout p%0d: no ack after %0d cycles, required ack", p, cyc);
        end else if (chk) begin
            exp_lat = e.err ? 1 : (w && sz != 2'b10) ? 3 : 2;
            exp_re  = (!e.err && (!w || sz != 2'b10)) ? 1 : 0;
            exp_we  = (!e.err && w) ? 1 : 0;
            if (cyc != exp_lat) begin
                errors++;
                $display("FAIL latency p%0d addr=%0h: got %0d required %0d", p, a, cyc, exp_lat);
            end
            checks++;
            if (nre != exp_re || nwe != exp_we) begin
                errors++;
                $display("FAIL strobes p%0d addr=%0h: re=%0d we=%0d required re=%0d we=%0d",
                         p, a, nre, nwe, exp_re, exp_we);
            end
        end
    endtask

    task automatic check_port(input int p);
        exp_t e;
        bit   empty;
        grant_log.push_back(p);
        empty = (p == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL unexpected_ack p%0d: got ack, required none", p);
        end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            $display("p%0d ack rdata=%08h err=%0b (exp rdata=%08h err=%0b)", p, rdata[p], err[p], e.rdata, e.err);
            if (err[p] != e.err || ((e.is_load || e.err) && rdata[p] != e.rdata)) begin
                errors++;
                $display("FAIL response p%0d: got rdata=%08h err=%0b required rdata=%08h err=%0b",
                         p, rdata[p], err[p], e.rdata, e.err);
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_n) begin
            if (mem_re || mem_we) begin
                checks++;
                if ((mem_re && mem_we) || mem_addr[1:0] != 2'b00) begin
                    errors++;
                    $display("FAIL strobe_rule: got re=%0b we=%0b addr=%0h required one strobe, aligned",
                             mem_re, mem_we, mem_addr);
                end
            end
            if (ack[0]) check_port(0);
            if (ack[1]) check_port(1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        int          n, mode, p;
        logic [1:0]  sz;
        logic [4:0]  a;
        int          exp_order[4];
        bit          done;

        for (int i = 0; i < 2; i++) begin
            req[i] = 0; wr[i] = 0; size[i] = 0; uns[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            init_words[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = init_words[i][8*b +: 8];
        end
        reset_n  = 1'b0;
        load_mem = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        load_mem = 1'b0;
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end

        // Both ports request continuously out of reset: word loads, p0 at 0x00, p1 at 0x10.
        wr[0] = 0; size[0] = 2'b10; addr[0] = 5'h00;
        wr[1] = 0; size[1] = 2'b10; addr[1] = 5'h10;
        req[0] = 1; req[1] = 1;
`ifdef DMEM_ARB_CORE_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            model(1'b0, 2'b10, 1'b0, (exp_order[i] == 0) ? 5'h00 : 5'h10, 32'd0, e);
            push_exp(exp_order[i], e);
        end
        @(posedge clk_i); #1;
        reset_n = 1'b1;
        n = 0;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk_i); #1;
            if (ack[0] || ack[1]) n++;
            if (n == 4) done = 1;
        end
        req[0] = 0; req[1] = 0;
        @(negedge clk_i); #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
                errors++;
                $display("FAIL grant_order[%0d]: got %0d required %0d", i,
                         (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            end
        end

        // Directed sequence from the plan.
        issue(0, 1, 2'b10, 0, 5'h04, 32'hDEADBEEF, 1);
        issue(0, 0, 2'b10, 0, 5'h04, 32'h0, 1);
        issue(1, 1, 2'b00, 0, 5'h06, 32'h00000055, 1);
        checks++;
        if (mem[1] != 32'hDE55BEEF) begin
            errors++;
            $display("FAIL rmw_word: got %08h required DE55BEEF", mem[1]);
        end
        issue(0, 0, 2'b00, 0, 5'h07, 32'h0, 1);
        issue(1, 0, 2'b00, 1, 5'h07, 32'h0, 1);
        issue(0, 0, 2'b01, 0, 5'h03, 32'h0, 1);
        issue(1, 0, 2'b11, 0, 5'h00, 32'h0, 1);
        issue(0, 1, 2'b01, 0, 5'h0A, 32'h0000C3A7, 1);
        issue(1, 0, 2'b01, 0, 5'h0A, 32'h0, 1);
        issue(0, 0, 2'b01, 1, 5'h0A, 32'h0, 1);

        // Randomized traffic; concurrent requests use disjoint halves of memory.
        for (int t = 0; t < 60; t++) begin
            mode = $urandom_range(0, 2);
            if (mode < 2) begin
                p  = mode;
                sz = 2'($urandom_range(0, 3));
                a  = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~5'((1 << sz) - 1);
                issue(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1);
            end else begin
                fork
                    begin
                        logic [1:0] s0;
                        logic [4:0] a0;
                        s0 = 2'($urandom_range(0, 2));
                        a0 = 5'($urandom_range(0, 15)) & ~5'((1 << s0) - 1);
                        issue(0, 1'($urandom_range(0, 1)), s0, 1'($urandom_range(0, 1)), a0, $urandom, 0);
                    end
                    begin
                        logic [1:0] s1;
                        logic [4:0] a1;
                        s1 = 2'($urandom_range(0, 2));
                        a1 = (5'd16 | 5'($urandom_range(0, 15))) & ~5'((1 << s1) - 1);
                        issue(1, 1'($urandom_range(0, 1)), s1, 1'($urandom_range(0, 1)), a1, $urandom, 0);
                    end
                join
            end
        end

        // Reset asserted during RMW_WR of a byte store to 0x08.
        @(posedge clk_i); #1;
        wr[0] = 1; size[0] = 2'b00; uns[0] = 0; addr[0] = 5'h08; wdata[0] = 32'h000000A5 ^ 32'(ref_mem[8]);
        req[0] = 1;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk_i); #1;
            if (mem_re) done = 1;
        end
        @(posedge clk_i); #1;
        checks++;
        if (!mem_we) begin
            errors++;
            $display("FAIL rmw_phase: got mem_we=%0b required 1", mem_we);
        end
        reset_n = 1'b0;
        #1;
        req[0] = 0;
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL abort_outputs: got we=%0b re=%0b ack=%0b/%0b required all 0",
                     mem_we, mem_re, ack[0], ack[1]);
        end
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (mem[2] != ref_word(2)) begin
            errors++;
            $display("FAIL abort_mem: got %08h required %08h", mem[2], ref_word(2));
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;

        for (int w = 0; w < 8; w++) begin
            checks++;
            if (mem[w] != ref_word(w)) begin
                errors++;
                $display("FAIL mem_word[%0d]: got %08h required %08h", w, mem[w], ref_word(w));
            end
        end
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d/%0d unanswered required 0/0", exp_q0.size(), exp_q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
